interboard_tx: RTL

INTERBOARD_TX -- requirements
Module: interboard_tx

---
 rtl/interboard_tx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/interboard_tx.sv
// interboard_tx
// Sends a 24-bit message to the peer board as four 6-bit words using a
// four-phase Request/Ack handshake. Ack is resynchronised to clk, and every
// wait for an Ack edge is bounded by a timeout that aborts the frame.
module interboard_tx #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic       ctrl_en,
  input  logic       ctrl_move_dir,
  input  logic [3:0] ctrl_msg_type,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       ack_in,
  output logic       req_out,
  output logic [5:0] data_out,
  output logic       drive_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // The counter serves both the setup delay (at most 15) and the ack timeout.
  // $clog2(N) bits always hold N-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 16) ? $clog2(TIMEOUT_CYCLES) : 4;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_ACK_HI,
    S_WAIT_ACK_LO
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_wi, w_wi;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [23:0]      r_frame, w_frame;
  logic [5:0]       r_data, w_data;
  logic             r_req, w_req;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             r_ackMeta, r_ackSync;
  logic [23:0]      w_capture;
  logic [1:0]       w_nextWi;

  assign w_capture = {1'b0, ctrl_en, ctrl_move_dir, ctrl_msg_type,
                      ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len};
  assign w_nextWi  = r_wi + 2'd1;

  // Word k occupies bits 23-6k down to 18-6k; word 0 is the most significant.
  function automatic logic [5:0] wordSel(input logic [23:0] frame,
                                         input logic [1:0]  idx);
    logic [5:0] word;
    case (idx)
      2'd0:    word = frame[23:18];
      2'd1:    word = frame[17:12];
      2'd2:    word = frame[11:6];
      default: word = frame[5:0];
    endcase
    return word;
  endfunction

  // Two-flop synchronizer bringing the peer's Ack into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ackMeta <= 1'b0;
      r_ackSync <= 1'b0;
    end else begin
      r_ackMeta <= ack_in;
      r_ackSync <= r_ackMeta;
    end
  end

  // State register plus every registered output, so the pins never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wi    <= 2'd0;
      r_cnt   <= '0;
      r_frame <= 24'd0;
      r_data  <= 6'd0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wi    <= w_wi;
      r_cnt   <= w_cnt;
      r_frame <= w_frame;
      r_data  <= w_data;
      r_req   <= w_req;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // Next-state logic. The counter restarts on every state change. A timeout
  // in either wait state drops Request and the data pins and flags err.
  // Data only changes on capture or on SETUP entry, so it is stable while
  // Request is high and while waiting for Ack to fall.
  always_comb begin
    w_state = r_state;
    w_wi    = r_wi;
    w_cnt   = r_cnt;
    w_frame = r_frame;
    w_data  = r_data;
    w_req   = r_req;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (transmit && !r_done && !r_err) begin
          w_frame = w_capture;
          w_wi    = 2'd0;
          w_data  = wordSel(w_capture, 2'd0);
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_req   = 1'b1;
          w_cnt   = '0;
          w_state = S_WAIT_ACK_HI;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_ACK_HI: begin
        if (r_ackSync) begin
          w_req   = 1'b0;
          w_cnt   = '0;
          w_state = S_WAIT_ACK_LO;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_req   = 1'b0;
          w_data  = 6'd0;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_wi    = 2'd0;
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_ACK_LO: begin
        if (!r_ackSync) begin
          w_cnt = '0;
          if (r_wi != 2'd3) begin
            w_wi    = w_nextWi;
            w_data  = wordSel(r_frame, w_nextWi);
            w_state = S_SETUP;
          end else begin
            w_wi    = 2'd0;
            w_data  = 6'd0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_req   = 1'b0;
          w_data  = 6'd0;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_wi    = 2'd0;
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign req_out  = r_req;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign drive_en = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
